// File: rtl/ping_echo_timer.sv
// ping_echo_timer
//   Time-of-flight capture stage. A ping strobe opens a listen window of
//   WINDOW cycles and clears the timer. Each accepted echo strobe pushes the
//   current timer value into a small timestamp FIFO, bumps a saturating echo
//   counter and starts a holdoff period during which further echoes are
//   ignored. done_stb pulses on the last window cycle.
//
//   Optional feature macro: PING_BLANK_EN. When defined, echoes arriving while
//   timer < BLANK are ignored to mask direct tx feedthrough.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   ping_stb    in   1-cycle launch strobe (honoured only in IDLE)
//   echo_stb    in   1-cycle RF receive strobe
//   busy        out  window open (LISTEN or HOLD)
//   echo_count  out  accepted echoes since last ping, saturating
//   overflow    out  sticky: an echo was accepted while the FIFO was full
//   done_stb    out  1-cycle pulse on the last window cycle
//   ts_data     out  FIFO head timestamp
//   ts_valid    out  FIFO not empty
//   ts_ready    in   consumer pop
//   dbg_state   out  current FSM state (0 IDLE, 1 LISTEN, 2 HOLD)
//
// Handshake: a pop happens on a clock edge where ts_valid && ts_ready are
// both high; ts_valid never depends on ts_ready, and ts_data holds the head
// value stable until it is popped.
module ping_echo_timer #(
  parameter int TW      = 16,
  parameter int WINDOW  = 32768,
  parameter int HOLDOFF = 256,
  parameter int DEPTH   = 8,
  parameter int CW      = 8,
  parameter int BLANK   = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ping_stb,
  input  logic          echo_stb,
  output logic          busy,
  output logic [CW-1:0] echo_count,
  output logic          overflow,
  output logic          done_stb,
  output logic [TW-1:0] ts_data,
  output logic          ts_valid,
  input  logic          ts_ready,
  output logic [1:0]    dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LISTEN = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [TW-1:0]  r_timer;
  logic [HW-1:0]  r_hold;
  logic [CW-1:0]  r_count;
  logic           r_overflow;
  logic [TW-1:0]  r_mem [DEPTH];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [AW:0]    r_fill;

  logic w_start;
  logic w_last;
  logic w_blank_ok;
  logic w_accept;
  logic w_full;
  logic w_pop;
  logic w_push;

`ifdef PING_BLANK_EN
  assign w_blank_ok = (r_timer >= TW'(BLANK));
`else
  assign w_blank_ok = 1'b1;
`endif

  assign w_start  = (r_state == S_IDLE) && ping_stb;
  assign w_last   = (r_state != S_IDLE) && (r_timer == TW'(WINDOW - 1));
  assign w_accept = (r_state == S_LISTEN) && echo_stb && w_blank_ok;
  assign w_full   = (r_fill == (AW+1)'(DEPTH));
  assign w_pop    = ts_valid && ts_ready;
  // A pop frees the slot the push writes into, so a full FIFO still accepts.
  assign w_push   = w_accept && (!w_full || w_pop);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next state; window end overrides everything else
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (ping_stb) w_next = S_LISTEN;
      S_LISTEN: begin
        if (w_last)        w_next = S_IDLE;
        else if (w_accept) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (w_last)              w_next = S_IDLE;
        else if (r_hold == '0)   w_next = S_LISTEN;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Timer, holdoff, counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer    <= '0;
      r_hold     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_start)                r_timer <= '0;
      else if (r_state != S_IDLE) r_timer <= r_timer + 1'b1;

      if (w_accept)                           r_hold <= HW'(HOLDOFF - 1);
      else if (r_state == S_HOLD && r_hold != '0) r_hold <= r_hold - 1'b1;

      if (w_start) begin
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (w_accept) begin
        if (r_count != '1)       r_count    <= r_count + 1'b1;
        if (w_full && !w_pop)    r_overflow <= 1'b1;
      end
    end
  end

  // Timestamp FIFO; a ping flush takes priority over a same-cycle pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fill <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_start) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= r_timer;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_fill <= r_fill + 1'b1;
      else if (w_pop && !w_push) r_fill <= r_fill - 1'b1;
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign echo_count = r_count;
  assign overflow   = r_overflow;
  assign done_stb   = w_last;
  assign ts_data    = r_mem[r_rd];
  assign ts_valid   = (r_fill != '0);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_ping_echo_timer.sv
// Directed bench for ping_echo_timer with WINDOW=1024, HOLDOFF=16, DEPTH=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// t tracks the timer value of the current cycle after a ping.
module tb_ping_echo_timer;
  localparam int TW = 16, WINDOW = 1024, HOLDOFF = 16, DEPTH = 4, CW = 8, BLANK = 64;

  logic          clk = 1'b0;
  logic          rst, ping_stb, echo_stb, ts_ready;
  logic          busy, overflow, done_stb, ts_valid;
  logic [CW-1:0] echo_count;
  logic [TW-1:0] ts_data;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;

  ping_echo_timer #(.TW(TW), .WINDOW(WINDOW), .HOLDOFF(HOLDOFF), .DEPTH(DEPTH),
                    .CW(CW), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .ping_stb(ping_stb), .echo_stb(echo_stb),
    .busy(busy), .echo_count(echo_count), .overflow(overflow),
    .done_stb(done_stb), .ts_data(ts_data), .ts_valid(ts_valid),
    .ts_ready(ts_ready), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic do_ping();
    ping_stb = 1'b1;
    @(negedge clk);
    ping_stb = 1'b0;
    t = 0;
  endtask

  task automatic advance_to(input int target);
    while (t < target) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic echo_at(input int target);
    advance_to(target);
    echo_stb = 1'b1;
    @(negedge clk);
    echo_stb = 1'b0;
    t++;
  endtask

  task automatic pop_check(input int exp, input string name);
    n_checks++;
    if (ts_valid !== 1'b1 || ts_data !== TW'(exp)) begin
      n_errors++;
      $display("FAIL %s: ts_valid=%0b ts_data=%0d, expected valid=1 data=%0d", name, ts_valid, ts_data, exp);
    end
    ts_ready = 1'b1;
    @(negedge clk);
    ts_ready = 1'b0;
    t++;
  endtask

  task automatic finish_window(input string name);
    advance_to(WINDOW - 1);
    @(negedge clk);
    t++;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s: busy=%0b after window, expected 0", name, busy);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if (busy !== 1'b0 || echo_count !== '0 || overflow !== 1'b0 || done_stb !== 1'b0 ||
        ts_data !== '0 || ts_valid !== 1'b0 || dbg_state !== 2'd0) begin
      n_errors++;
      $display("FAIL %s: busy=%0b cnt=%0d ovf=%0b done=%0b data=%0d valid=%0b st=%0d, expected all 0",
               name, busy, echo_count, overflow, done_stb, ts_data, ts_valid, dbg_state);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_ping();
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy_rise: busy=%0b, expected 1", busy); end
    echo_at(100);
    n_checks++;
    if (ts_valid !== 1'b1 || ts_data !== 16'd100 || echo_count !== 8'd1) begin
      n_errors++;
      $display("FAIL basic_push: valid=%0b data=%0d cnt=%0d, expected 1/100/1", ts_valid, ts_data, echo_count);
    end
    advance_to(1022);
    n_checks++;
    if (done_stb !== 1'b0) begin n_errors++; $display("FAIL basic_done_early: done=%0b at 1022, expected 0", done_stb); end
    advance_to(1023);
    n_checks++;
    if (done_stb !== 1'b1 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_done: done=%0b busy=%0b at 1023, expected 1/1", done_stb, busy);
    end
    @(negedge clk);
    t++;
    n_checks++;
    if (busy !== 1'b0 || done_stb !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_busy_fall: busy=%0b done=%0b, expected 0/0", busy, done_stb);
    end
    pop_check(100, "basic_pop");
    n_checks++;
    if (ts_valid !== 1'b0) begin n_errors++; $display("FAIL basic_empty: ts_valid=%0b, expected 0", ts_valid); end
  endtask

  task automatic test_holdoff();
    do_ping();
    echo_at(200);
    echo_at(210);
    echo_at(217);
    n_checks++;
    if (echo_count !== 8'd2) begin n_errors++; $display("FAIL holdoff_count: cnt=%0d, expected 2", echo_count); end
    finish_window("holdoff_end");
    pop_check(200, "holdoff_pop0");
    pop_check(217, "holdoff_pop1");
    n_checks++;
    if (ts_valid !== 1'b0) begin n_errors++; $display("FAIL holdoff_empty: ts_valid=%0b, expected 0", ts_valid); end
  endtask

  task automatic test_overflow();
    do_ping();
    for (int i = 1; i <= 5; i++) echo_at(100 * i);
    n_checks++;
    if (echo_count !== 8'd5 || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_flags: cnt=%0d ovf=%0b, expected 5/1", echo_count, overflow);
    end
    finish_window("ovf_end");
    for (int i = 1; i <= 4; i++) pop_check(100 * i, "ovf_pop");
    n_checks++;
    if (ts_valid !== 1'b0 || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_drain: valid=%0b ovf=%0b, expected 0/1 (sticky)", ts_valid, overflow);
    end
  endtask

  task automatic test_full_pop();
    do_ping();
    n_checks++;
    if (overflow !== 1'b0 || echo_count !== 8'd0) begin
      n_errors++;
      $display("FAIL fullpop_clear: ovf=%0b cnt=%0d, expected 0/0", overflow, echo_count);
    end
    for (int i = 1; i <= 4; i++) echo_at(100 * i);
    advance_to(500);
    echo_stb = 1'b1;
    ts_ready = 1'b1;
    @(negedge clk);
    echo_stb = 1'b0;
    ts_ready = 1'b0;
    t++;
    n_checks++;
    if (overflow !== 1'b0 || echo_count !== 8'd5) begin
      n_errors++;
      $display("FAIL fullpop_flags: ovf=%0b cnt=%0d, expected 0/5", overflow, echo_count);
    end
    finish_window("fullpop_end");
    for (int i = 2; i <= 5; i++) pop_check(100 * i, "fullpop_pop");
  endtask

  task automatic test_window_end();
    do_ping();
    echo_at(300);
    advance_to(600);
    ping_stb = 1'b1;
    @(negedge clk);
    ping_stb = 1'b0;
    t++;
    n_checks++;
    if (echo_count !== 8'd1 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_ping_ignored: cnt=%0d busy=%0b, expected 1/1", echo_count, busy);
    end
    advance_to(1023);
    echo_stb = 1'b1;
    n_checks++;
    if (done_stb !== 1'b1) begin n_errors++; $display("FAIL lastcycle_done: done=%0b, expected 1", done_stb); end
    @(negedge clk);
    echo_stb = 1'b0;
    t++;
    n_checks++;
    if (echo_count !== 8'd2 || busy !== 1'b0 || ts_data !== 16'd300) begin
      n_errors++;
      $display("FAIL lastcycle_echo: cnt=%0d busy=%0b head=%0d, expected 2/0/300", echo_count, busy, ts_data);
    end
    pop_check(300, "lastcycle_pop0");
    n_checks++;
    if (ts_valid !== 1'b1 || ts_data !== 16'd1023) begin
      n_errors++;
      $display("FAIL lastcycle_head: valid=%0b data=%0d, expected 1/1023", ts_valid, ts_data);
    end
    // ping in IDLE with a pending pop: flush must win
    ts_ready = 1'b1;
    do_ping();
    ts_ready = 1'b0;
    n_checks++;
    if (ts_valid !== 1'b0 || echo_count !== 8'd0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL idle_ping_flush: valid=%0b cnt=%0d busy=%0b, expected 0/0/1", ts_valid, echo_count, busy);
    end
    finish_window("flush_end");
  endtask

  task automatic test_blank_and_abort();
    bit saw_activity;
    do_ping();
    echo_at(10);
    echo_at(64);
`ifdef PING_BLANK_EN
    n_checks++;
    if (echo_count !== 8'd1 || ts_data !== 16'd64) begin
      n_errors++;
      $display("FAIL blank_on: cnt=%0d head=%0d, expected 1/64", echo_count, ts_data);
    end
`else
    // 64 is 54 cycles after 10, past the 17-cycle holdoff, so both land
    n_checks++;
    if (echo_count !== 8'd2 || ts_data !== 16'd10) begin
      n_errors++;
      $display("FAIL blank_off: cnt=%0d head=%0d, expected 2/10", echo_count, ts_data);
    end
`endif
    advance_to(300);
    rst = 1'b1;
    @(negedge clk);
    t++;
    check_idle_outputs("abort_reset");
    rst = 1'b0;
    saw_activity = 1'b0;
    for (int i = 0; i < WINDOW + 16; i++) begin
      @(negedge clk);
      if (done_stb !== 1'b0 || busy !== 1'b0) saw_activity = 1'b1;
    end
    n_checks++;
    if (saw_activity) begin n_errors++; $display("FAIL abort_no_done: done/busy seen after abort, expected none"); end
  endtask

  initial begin
    rst = 1'b1;
    ping_stb = 1'b0;
    echo_stb = 1'b0;
    ts_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_holdoff();
    test_overflow();
    test_full_pop();
    test_window_end();
    test_blank_and_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
